// File: rtl/cla_nibble_sequencer_if.sv
// Operand/result handshake bundle for the nibble-serial CLA adder.
// The master side feeds operands and takes results; the slave side is the adder.
interface cla_nibble_sequencer_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice processes the operands
// LSB nibble first, with the inter-nibble carry held in a register.
module cla_nibble_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input logic                    clk,
    input logic                    rst,
    cla_nibble_sequencer_if.slave  bus
);
    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NIB - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] s;

    // Lookahead slice over the low nibble of the operand shift registers.
    always_comb begin
        g    = a_q[3:0] & b_q[3:0];
        p    = a_q[3:0] ^ b_q[3:0];
        c    = '0;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s    = p ^ c[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_q      <= a_q >> 4;
                    b_q      <= b_q >> 4;
                    sum_sh_q <= {s, sum_sh_q[WIDTH-1:4]};
                    carry_q  <= c[4];
                    cnt_q    <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        // Result outputs change only here, so they hold across the handoff.
                        sum_q   <= {s, sum_sh_q[WIDTH-1:4]};
                        cout_q  <= c[4];
                        ovf_q   <= c[3] ^ c[4];
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle) & ~rst;
    assign bus.out_valid = (state_q == StDone);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed and randomised checks for the nibble-serial CLA adder at WIDTH = 16.
module tb_cla_nibble_sequencer;
    localparam int unsigned WIDTH = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cla_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

    cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation at a negedge, check latency and result, then hand it off.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] exp_sum, input logic exp_cout,
                          input logic exp_ovf);
        int lat;
        lat = 0;
        while (!bus.in_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_ovalid_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    logic [15:0] ra;
    logic [15:0] rb;
    logic        rcin;
    logic [32:0] q_ops[$];
    logic [32:0] op;
    logic [16:0] full;
    logic [15:0] low;
    logic        c15;
    int          issued;
    int          done;
    int          cyc;
    int          last_acc;

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        run_op("ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("7fff_1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("1234_4321", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        run_op("0fff_cin", 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);

        // Backpressure with an in_valid pulse that must be ignored outside IDLE.
        bus.in_valid = 1'b1;
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.cin      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.a = 16'hAAAA;
        bus.b = 16'h5555;
        cyc   = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("bp_latency", 32'(cyc), 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_sum", 32'(bus.sum), 32'h3333);
            chk("bp_cout", 32'(bus.cout), 32'd0);
            chk("bp_ovf", 32'(bus.overflow), 32'd0);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_ready_after", 32'(bus.in_ready), 32'd1);
        chk("bp_sum_held", 32'(bus.sum), 32'h3333);
        repeat (6) @(negedge clk);
        chk("bp_no_capture", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset between E2 and E3.
        bus.in_valid = 1'b1;
        bus.a        = 16'h00FF;
        bus.b        = 16'h0001;
        bus.cin      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_sum", 32'(bus.sum), 32'd0);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst_ready_after", 32'(bus.in_ready), 32'd1);
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) cyc++;
        end
        chk("arst_no_out_valid", 32'(cyc), 32'd0);
        run_op("3_4", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

        // Back-to-back random stream with in_valid and out_ready tied high.
        issued   = 0;
        done     = 0;
        cyc      = 0;
        last_acc = 0;
        bus.out_ready = 1'b1;
        while (done < 200 && cyc < 2000) begin
            if (bus.out_valid && q_ops.size() > 0) begin
                op   = q_ops.pop_front();
                full = {1'b0, op[32:17]} + {1'b0, op[16:1]} + 17'(op[0]);
                low  = {1'b0, op[31:17]} + {1'b0, op[15:1]} + 16'(op[0]);
                c15  = low[15];
                chk("rnd_sum", 32'(bus.sum), 32'(full[15:0]));
                chk("rnd_cout", 32'(bus.cout), 32'(full[16]));
                chk("rnd_ovf", 32'(bus.overflow), 32'(c15 ^ full[16]));
                done++;
            end
            if (bus.in_ready) begin
                if (issued < 200) begin
                    ra           = 16'($urandom);
                    rb           = 16'($urandom);
                    rcin         = 1'($urandom);
                    bus.a        = ra;
                    bus.b        = rb;
                    bus.cin      = rcin;
                    bus.in_valid = 1'b1;
                    q_ops.push_back({ra, rb, rcin});
                    if (issued > 0) chk("rnd_interval", 32'(cyc - last_acc), 32'd6);
                    last_acc = cyc;
                    issued++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("rnd_all_done", 32'(done), 32'd200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
